// File: rtl/cdc_event_sync.sv
`timescale 1ns/1ps
// cdc_event_sync: per-channel event synchroniser with pending-event counter.
// Each asynchronous event line is synchronised into receiver_clk_i. It is then
// edge-detected: either edge counts in toggle mode, only rising edges count in
// level mode. Each detected event gives a one-cycle pulse and adds one to a
// saturating pending count. A consumer drains that count one event at a time
// with a valid/ready handshake. A sticky flag reports events that were dropped
// because the counter was already full.
//
// Ports:
//   receiver_clk_i     - receiving-domain clock, all flops rising-edge
//   receiver_reset_ni  - asynchronous active-low reset
//   event_async_i      - [CHANNELS] asynchronous event lines
//   receiver_pulse_o   - [CHANNELS] one-cycle pulse per detected event
//   event_valid_o      - [CHANNELS] channel has at least one pending event
//   event_ready_i      - [CHANNELS] consumer takes one pending event
//   overflow_o         - [CHANNELS] sticky: an event was dropped
//   overflow_clr_i     - [CHANNELS] clears the matching overflow_o bit
module cdc_event_sync #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned CNT_WIDTH   = 3
) (
  input  logic                receiver_clk_i,
  input  logic                receiver_reset_ni,
  input  logic [CHANNELS-1:0] event_async_i,
  output logic [CHANNELS-1:0] receiver_pulse_o,
  output logic [CHANNELS-1:0] event_valid_o,
  input  logic [CHANNELS-1:0] event_ready_i,
  output logic [CHANNELS-1:0] overflow_o,
  input  logic [CHANNELS-1:0] overflow_clr_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;   // bit 0 is the first capture stage
    logic                   sync_s;
    logic                   hist_q;
    logic                   detect_c;
    logic                   pop_c;
    logic                   ovf_set_c;
    logic                   pulse_q;
    logic                   valid_q;
    logic                   ovf_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;

    // Plain flop chain: nothing may sit between synchroniser stages.
    always_ff @(posedge receiver_clk_i or negedge receiver_reset_ni) begin
      if (!receiver_reset_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], event_async_i[ch]};
      end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // hist resets to 0 so a line held high through reset reads as one event.
    if (EDGE_MODE == 0) begin : g_toggle
      assign detect_c = sync_s ^ hist_q;
    end else begin : g_level
      assign detect_c = sync_s & ~hist_q;
    end

    // valid_q already implies cnt_q != 0, so a pop can never underflow.
    assign pop_c = valid_q & event_ready_i[ch];

    // Pending-count update; a simultaneous detect and pop cancel out even when full.
    always_comb begin
      cnt_d     = cnt_q;
      ovf_set_c = 1'b0;
      if (detect_c && !pop_c) begin
        if (cnt_q == CNT_MAX) begin
          ovf_set_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end else if (pop_c && !detect_c) begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
      end
    end

    // Output and counter registers; valid tracks the next count so it stays registered.
    always_ff @(posedge receiver_clk_i or negedge receiver_reset_ni) begin
      if (!receiver_reset_ni) begin
        hist_q  <= 1'b0;
        pulse_q <= 1'b0;
        cnt_q   <= '0;
        valid_q <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        hist_q  <= sync_s;
        pulse_q <= detect_c;
        cnt_q   <= cnt_d;
        valid_q <= (cnt_d != '0);
        ovf_q   <= ovf_set_c | (ovf_q & ~overflow_clr_i[ch]);
      end
    end

    assign receiver_pulse_o[ch] = pulse_q;
    assign event_valid_o[ch]    = valid_q;
    assign overflow_o[ch]       = ovf_q;
  end

endmodule

// File: tb/tb_cdc_event_sync.sv
`timescale 1ns/1ps
// Self-checking bench for cdc_event_sync.
// Instance A uses default parameters (toggle mode, 4 channels).
// Instance B uses level mode with 2 channels.
module tb_cdc_event_sync;

  localparam int unsigned CH   = 4;
  localparam int unsigned CHB  = 2;
  localparam int unsigned SS   = 2;
  localparam int          CMAX = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [CH-1:0]  ev_a = '0, rdy_a = '0, clr_a = '0;
  logic [CH-1:0]  pulse_a, valid_a, ovf_a;
  logic [CHB-1:0] ev_b = '0, rdy_b = '0, clr_b = '0;
  logic [CHB-1:0] pulse_b, valid_b, ovf_b;

  always #5 clk = ~clk;

  cdc_event_sync u_dut_a (
    .receiver_clk_i   (clk),
    .receiver_reset_ni(rst_n),
    .event_async_i    (ev_a),
    .receiver_pulse_o (pulse_a),
    .event_valid_o    (valid_a),
    .event_ready_i    (rdy_a),
    .overflow_o       (ovf_a),
    .overflow_clr_i   (clr_a)
  );

  cdc_event_sync #(.CHANNELS(CHB), .SYNC_STAGES(SS), .EDGE_MODE(1), .CNT_WIDTH(3)) u_dut_b (
    .receiver_clk_i   (clk),
    .receiver_reset_ni(rst_n),
    .event_async_i    (ev_b),
    .receiver_pulse_o (pulse_b),
    .event_valid_o    (valid_b),
    .event_ready_i    (rdy_b),
    .overflow_o       (ovf_b),
    .overflow_clr_i   (clr_b)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a history of the input value seen at each edge, plus integer
  // pending counts. An input change first seen at edge E0 is an event at E0+SS.
  logic [CH-1:0]  smp_a [$];
  logic [CHB-1:0] smp_b [$];
  int             cnt_a [CH];
  int             cnt_b [CHB];
  logic [CH-1:0]  m_ovf_a, exp_pulse_a, exp_valid_a;
  logic [CHB-1:0] m_ovf_b, exp_pulse_b, exp_valid_b;

  task automatic model_clear();
    smp_a = {};
    smp_b = {};
    for (int i = 0; i < SS + 2; i++) begin
      smp_a.push_front('0);
      smp_b.push_front('0);
    end
    foreach (cnt_a[i]) cnt_a[i] = 0;
    foreach (cnt_b[i]) cnt_b[i] = 0;
    m_ovf_a = '0; exp_pulse_a = '0; exp_valid_a = '0;
    m_ovf_b = '0; exp_pulse_b = '0; exp_valid_b = '0;
  endtask

  // Advance one clock edge, update the model, then settle 1ns past the edge.
  task automatic step();
    logic [CH-1:0]  ev;
    logic [CHB-1:0] evb;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      smp_a.push_front(ev_a);
      void'(smp_a.pop_back());
      smp_b.push_front(ev_b);
      void'(smp_b.pop_back());
      ev  = smp_a[SS] ^ smp_a[SS+1];
      evb = smp_b[SS] & ~smp_b[SS+1];
      for (int c = 0; c < CH; c++) begin
        int pop;
        int nxt;
        pop = (cnt_a[c] > 0 && rdy_a[c]) ? 1 : 0;
        nxt = cnt_a[c] + (ev[c] ? 1 : 0) - pop;
        m_ovf_a[c] = m_ovf_a[c] & ~clr_a[c];
        if (nxt > CMAX) begin
          nxt = CMAX;
          m_ovf_a[c] = 1'b1;
        end
        cnt_a[c] = nxt;
        exp_valid_a[c] = (nxt != 0);
      end
      for (int c = 0; c < CHB; c++) begin
        int pop;
        int nxt;
        pop = (cnt_b[c] > 0 && rdy_b[c]) ? 1 : 0;
        nxt = cnt_b[c] + (evb[c] ? 1 : 0) - pop;
        m_ovf_b[c] = m_ovf_b[c] & ~clr_b[c];
        if (nxt > CMAX) begin
          nxt = CMAX;
          m_ovf_b[c] = 1'b1;
        end
        cnt_b[c] = nxt;
        exp_valid_b[c] = (nxt != 0);
      end
      exp_pulse_a = ev;
      exp_pulse_b = evb;
    end
    #1;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (pulse_a !== 4'b0000) begin errors++; $display("FAIL reset_pulse_a got=%b exp=0000", pulse_a); end
    checks++; if (valid_a !== 4'b0000) begin errors++; $display("FAIL reset_valid_a got=%b exp=0000", valid_a); end
    checks++; if (ovf_a !== 4'b0000) begin errors++; $display("FAIL reset_ovf_a got=%b exp=0000", ovf_a); end
    checks++; if ({pulse_b, valid_b, ovf_b} !== 6'b0) begin errors++; $display("FAIL reset_b got=%b exp=000000", {pulse_b, valid_b, ovf_b}); end
    rst_n = 1'b1;
    repeat (2) step();
    checks++; if ({pulse_a, valid_a, ovf_a} !== 12'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", {pulse_a, valid_a, ovf_a}); end
  endtask

  task automatic test_single_toggle();
    logic [CH-1:0] want_p [4];
    want_p[0] = 4'b0000; want_p[1] = 4'b0000; want_p[2] = 4'b0001; want_p[3] = 4'b0000;
    ev_a[0] = ~ev_a[0];
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (pulse_a !== want_p[i]) begin errors++; $display("FAIL single_pulse cyc=%0d got=%b exp=%b", i, pulse_a, want_p[i]); end
      checks++; if (pulse_a !== exp_pulse_a || valid_a !== exp_valid_a) begin errors++; $display("FAIL single_model cyc=%0d got=%b/%b exp=%b/%b", i, pulse_a, valid_a, exp_pulse_a, exp_valid_a); end
    end
    checks++; if (valid_a !== 4'b0001) begin errors++; $display("FAIL single_valid got=%b exp=0001", valid_a); end
    rdy_a[0] = 1'b1;
    step();
    rdy_a[0] = 1'b0;
    checks++; if (valid_a !== 4'b0000) begin errors++; $display("FAIL single_pop got=%b exp=0000", valid_a); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 9; k++) begin
      ev_a[2] = ~ev_a[2];
      repeat (4) begin
        step();
        checks++; if (pulse_a !== exp_pulse_a || valid_a !== exp_valid_a || ovf_a !== m_ovf_a) begin errors++; $display("FAIL ovf_model ev=%0d got=%b/%b/%b exp=%b/%b/%b", k, pulse_a, valid_a, ovf_a, exp_pulse_a, exp_valid_a, m_ovf_a); end
      end
      if (k == 6) begin checks++; if (ovf_a[2] !== 1'b0) begin errors++; $display("FAIL ovf_early got=%b exp=0", ovf_a[2]); end end
      if (k == 7) begin checks++; if (ovf_a[2] !== 1'b1) begin errors++; $display("FAIL ovf_at_8th got=%b exp=1", ovf_a[2]); end end
    end
    clr_a[2] = 1'b1;
    step();
    clr_a[2] = 1'b0;
    checks++; if (ovf_a[2] !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", ovf_a[2]); end
    // Clear lands on the same edge as a new overflow: the new overflow must win.
    ev_a[2] = ~ev_a[2];
    step();
    step();
    clr_a[2] = 1'b1;
    step();
    clr_a[2] = 1'b0;
    checks++; if (ovf_a[2] !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", ovf_a[2]); end
    rdy_a[2] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 5) begin checks++; if (valid_a[2] !== 1'b1) begin errors++; $display("FAIL drain6_valid got=%b exp=1", valid_a[2]); end end
      if (i == 6) begin checks++; if (valid_a[2] !== 1'b0) begin errors++; $display("FAIL drain7_valid got=%b exp=0", valid_a[2]); end end
    end
    rdy_a[2] = 1'b0;
    checks++; if (valid_a !== exp_valid_a || valid_a[2] !== 1'b0) begin errors++; $display("FAIL drain_idle got=%b exp=%b", valid_a, exp_valid_a); end
    clr_a[2] = 1'b1;
    step();
    clr_a[2] = 1'b0;
  endtask

  task automatic test_full_pop_same();
    repeat (7) begin
      ev_a[1] = ~ev_a[1];
      repeat (3) step();
    end
    step();
    ev_a[1] = ~ev_a[1];
    step();
    step();
    rdy_a[1] = 1'b1;
    step();
    rdy_a[1] = 1'b0;
    checks++; if (pulse_a[1] !== 1'b1) begin errors++; $display("FAIL full_pop_pulse got=%b exp=1", pulse_a[1]); end
    checks++; if (ovf_a[1] !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got=%b exp=0", ovf_a[1]); end
    rdy_a[1] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 5) begin checks++; if (valid_a[1] !== 1'b1) begin errors++; $display("FAIL full_pop_drain6 got=%b exp=1", valid_a[1]); end end
    end
    rdy_a[1] = 1'b0;
    checks++; if (valid_a[1] !== 1'b0 || valid_a !== exp_valid_a) begin errors++; $display("FAIL full_pop_drain7 got=%b exp=%b", valid_a, exp_valid_a); end
  endtask

  task automatic test_all_channels();
    ev_a = ~ev_a;
    repeat (3) step();
    checks++; if (pulse_a !== 4'b1111) begin errors++; $display("FAIL all_pulse got=%b exp=1111", pulse_a); end
    checks++; if (valid_a !== 4'b1111) begin errors++; $display("FAIL all_valid got=%b exp=1111", valid_a); end
    step();
    checks++; if (pulse_a !== 4'b0000) begin errors++; $display("FAIL all_pulse_end got=%b exp=0000", pulse_a); end
    rdy_a = 4'b1111;
    step();
    rdy_a = 4'b0000;
    checks++; if (valid_a !== 4'b0000) begin errors++; $display("FAIL all_drain got=%b exp=0000", valid_a); end
  endtask

  task automatic test_level_mode();
    int npulse = 0;
    ev_b[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) ev_b[1] = 1'b0;
      step();
      if (pulse_b[1]) npulse++;
      checks++; if (pulse_b !== exp_pulse_b) begin errors++; $display("FAIL level_model cyc=%0d got=%b exp=%b", i, pulse_b, exp_pulse_b); end
    end
    checks++; if (npulse !== 1) begin errors++; $display("FAIL level_count got=%0d exp=1", npulse); end
    checks++; if (valid_b !== 2'b10) begin errors++; $display("FAIL level_valid got=%b exp=10", valid_b); end
    rdy_b[1] = 1'b1;
    step();
    rdy_b[1] = 1'b0;
  endtask

  task automatic test_random();
    int age_a [CH];
    int age_b [CHB];
    foreach (age_a[i]) age_a[i] = 2;
    foreach (age_b[i]) age_b[i] = 2;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < CH; c++) begin
        if (age_a[c] >= 2 && $urandom_range(0, 2) == 0) begin ev_a[c] = ~ev_a[c]; age_a[c] = 0; end
        rdy_a[c] = ($urandom_range(0, 7) < ((cyc < 300) ? 1 : 5));
        clr_a[c] = ($urandom_range(0, 19) == 0);
      end
      for (int c = 0; c < CHB; c++) begin
        if (age_b[c] >= 2 && $urandom_range(0, 2) == 0) begin ev_b[c] = ~ev_b[c]; age_b[c] = 0; end
        rdy_b[c] = ($urandom_range(0, 3) == 0);
        clr_b[c] = ($urandom_range(0, 19) == 0);
      end
      step();
      foreach (age_a[i]) age_a[i]++;
      foreach (age_b[i]) age_b[i]++;
      checks++; if (pulse_a !== exp_pulse_a || valid_a !== exp_valid_a || ovf_a !== m_ovf_a) begin errors++; $display("FAIL rand_a cyc=%0d got=%b/%b/%b exp=%b/%b/%b", cyc, pulse_a, valid_a, ovf_a, exp_pulse_a, exp_valid_a, m_ovf_a); end
      checks++; if (pulse_b !== exp_pulse_b || valid_b !== exp_valid_b || ovf_b !== m_ovf_b) begin errors++; $display("FAIL rand_b cyc=%0d got=%b/%b/%b exp=%b/%b/%b", cyc, pulse_b, valid_b, ovf_b, exp_pulse_b, exp_valid_b, m_ovf_b); end
    end
    rdy_a = '0; clr_a = '0; rdy_b = '0; clr_b = '0;
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    repeat (3) begin
      ev_a[3] = ~ev_a[3];
      repeat (3) step();
    end
    repeat (2) step();
    checks++; if (valid_a[3] !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", valid_a[3]); end
    #2;
    rst_n = 1'b0;
    ev_a = '0;
    ev_b = '0;
    #1;
    checks++; if ({pulse_a, valid_a, ovf_a} !== 12'b0) begin errors++; $display("FAIL mid_async_a got=%b exp=0", {pulse_a, valid_a, ovf_a}); end
    checks++; if ({pulse_b, valid_b, ovf_b} !== 6'b0) begin errors++; $display("FAIL mid_async_b got=%b exp=0", {pulse_b, valid_b, ovf_b}); end
    // Line held high through reset must read as exactly one event afterwards.
    ev_a[1] = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pulse_a[1]) npulse++;
      checks++; if (pulse_a !== exp_pulse_a || valid_a !== exp_valid_a || ovf_a !== m_ovf_a) begin errors++; $display("FAIL mid_model cyc=%0d got=%b/%b/%b exp=%b/%b/%b", i, pulse_a, valid_a, ovf_a, exp_pulse_a, exp_valid_a, m_ovf_a); end
    end
    checks++; if (valid_a[3] !== 1'b0) begin errors++; $display("FAIL mid_discard got=%b exp=0", valid_a[3]); end
    checks++; if (npulse !== 1 || valid_a !== 4'b0010) begin errors++; $display("FAIL mid_held_high pulses=%0d valid=%b exp=1/0010", npulse, valid_a); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_toggle();
    test_overflow();
    test_full_pop_same();
    test_all_channels();
    test_level_mode();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
